// File: rtl/axis_i2c_slave.sv
`default_nettype none
// ============================================================================
// axis_i2c_slave : I2C slave; write bytes -> m_axis, read bytes <- s_axis.
// Optional I2C_GLITCH_FILTER_EN adds a 3-sample majority filter. Rev 1.0
// ============================================================================
module axis_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WR_DATA  = 3'd3,
    S_WR_ACK   = 3'd4,
    S_RD_DATA  = 3'd5,
    S_RD_ACK   = 3'd6
  } state_t;

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic       scl_line, sda_line;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], i2c_scl};
    sda_sync_d = {sda_sync_q[0], i2c_sda};
    scl_prev_d = scl_line;
    sda_prev_d = sda_line;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_line = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                    (scl_hist_q[1] & scl_hist_q[2]);
  assign sda_line = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                    (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign scl_line = scl_sync_q[1];
  assign sda_line = sda_sync_q[1];
`endif

  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_line & scl_prev_q & sda_prev_q & ~sda_line;
  assign stop_det  = scl_line & scl_prev_q & ~sda_prev_q & sda_line;
  assign scl_rise  = scl_line & ~scl_prev_q;
  assign scl_fall  = ~scl_line & scl_prev_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tdata_q, tdata_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       first_q, first_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tready_q, tready_d;
  logic [7:0] rx_byte, tx_byte;
  logic       out_room;

  assign rx_byte  = {shift_q[6:0], sda_line};
  assign tx_byte  = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE;
  assign out_room = ~tvalid_q | m_axis_tready;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sda_oe_d  = sda_oe_q;
    rw_d      = rw_q;
    ack_d     = ack_q;
    first_d   = first_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q & ~m_axis_tready;
    tready_d  = 1'b0;
    // Bus conditions pre-empt any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              first_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = S_RD_DATA;
              shift_d  = tx_byte;
              tready_d = s_axis_tvalid;
              sda_oe_d = ~tx_byte[7];
            end else begin
              state_d  = S_WR_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              ack_d = out_room;
              if (out_room) begin
                tdata_d  = rx_byte;
                tvalid_d = 1'b1;
                tlast_d  = first_q;
                first_d  = 1'b0;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = S_WR_ACK;
            sda_oe_d = ack_q;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_d   = S_WR_DATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        S_RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = S_RD_ACK;
            sda_oe_d = 1'b0;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        S_RD_ACK: begin
          // The falling edge is only reached after the master ACKed.
          if (scl_rise && sda_line) begin
            state_d = S_IDLE;
          end else if (scl_fall) begin
            state_d   = S_RD_DATA;
            bit_cnt_d = 4'd0;
            shift_d   = tx_byte;
            tready_d  = s_axis_tvalid;
            sda_oe_d  = ~tx_byte[7];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      sda_oe_q  <= 1'b0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      first_q   <= 1'b0;
      tdata_q   <= 8'd0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      first_q   <= first_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tready_q  <= tready_d;
    end
  end

  assign i2c_sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign s_axis_tready = tready_q;

endmodule
`default_nettype wire

// File: doc/axis_i2c_slave.md
AXIS_I2C_SLAVE -- requirements
Module: axis_i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF: byte sent on a read when no TX data is available.
REQ-003 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 arstn  input  1  reset, asynchronous assert, active-low.
REQ-005 i2c_scl  input  1  I2C clock from master; asynchronous to clk.
REQ-006 i2c_sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-007 m_axis_tdata  output  8  byte received in a write transfer.
REQ-008 m_axis_tvalid  output  1  received byte valid.
REQ-009 m_axis_tready  input  1  downstream accepts byte.
REQ-010 m_axis_tlast  output  1  high with the first byte after START+address; marks a new transaction.
REQ-011 s_axis_tdata  input  8  byte to return in a read transfer.
REQ-012 s_axis_tvalid  input  1  TX byte valid.
REQ-013 s_axis_tready  output  1  one-cycle pulse when a TX byte is loaded into the shifter.

Function
REQ-014 i2c_scl and i2c_sda SHALL each pass through a 2-flop synchronizer; all decoding uses synchronized values.
REQ-015 START = synchronized SDA falls while SCL high; STOP = SDA rises while SCL high; SCL rise/fall = edge of synchronized SCL.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-017 START in any state (including repeated START) -> ADDR, bit counter cleared, SDA released.
REQ-018 STOP in any state -> IDLE, SDA released.
REQ-019 Bits sampled on SCL rise, MSB first; slave changes SDA only on SCL fall.
REQ-020 ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR -> ADDR_ACK (SDA low for 9th clock); else -> IDLE, SDA untouched until next START.
REQ-021 After ADDR_ACK SCL fall: R/W=0 -> WR_DATA; R/W=1 -> RD_DATA, loading s_axis_tdata (pulsing s_axis_tready) if s_axis_tvalid, else IDLE_BYTE.
REQ-022 WR_DATA: after 8th SCL rise, if output register empty: load m_axis_tdata, assert m_axis_tvalid the next clk, ACK; if full: drop byte, NACK (SDA released); both -> WR_ACK -> WR_DATA on the 9th SCL fall.
REQ-023 Output register is single-entry: m_axis_tvalid held until tvalid&tready; tdata/tlast stable while tvalid&!tready.
REQ-024 RD_DATA: drive SDA low when current bit is 0, release when 1; after 8th SCL fall release SDA -> RD_ACK.
REQ-025 RD_ACK: sample SDA on 9th SCL rise; ACK (0) -> load next byte per REQ-021 on SCL fall, -> RD_DATA; NACK (1) -> IDLE, SDA released.
REQ-026 Bit counter 4 bits, 0..8, cleared on START and on each ACK-slot exit; no wrap beyond 8.
REQ-027 START and STOP detection SHALL take priority over same-cycle SCL edge processing.

Reset
REQ-028 While arstn low: state IDLE, SDA released (z), m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, synchronizers set to 1.
REQ-029 Reset mid-transaction SHALL drop any partial byte and pending output; after release the block waits for a fresh START.

Configuration
REQ-030 Macro I2C_GLITCH_FILTER_EN defined: each synchronized line also passes a 3-sample majority filter (adds 2 clk latency) rejecting pulses shorter than 2 clk.
REQ-031 Macro undefined: no filter; synchronizer output used directly; protocol behaviour otherwise identical.

Verification
REQ-032 Write: START, 0xA0, 0x3C, 0x5A, STOP, tready=1 -> ACK on all 3 bytes; m_axis bytes 0x3C (tlast=1), 0x5A (tlast=0).
REQ-033 Wrong address: START, 0x42, 0x11, STOP -> SDA never driven low; no m_axis_tvalid.
REQ-034 Read: s_axis supplies 0xC3, 0x7E; START, 0xA1, master ACK then NACK -> SDA carries 0xC3, 0x7E; two s_axis_tready pulses; IDLE after NACK.
REQ-035 Back-pressure: tready=0, write 0x01, 0x02 -> 0x01 ACKed and held; 0x02 NACKed; only 0x01 delivered once tready=1.
REQ-036 Repeated START: START, 0xA0, 0x10, Sr, 0xA1, read one byte with s_axis_tvalid=0, NACK, STOP -> 0x10 delivered; 0xFF returned.
REQ-037 arstn low mid-read (after 4 bits) -> SDA z within one clk, outputs at reset values; next full write transaction succeeds.
